cache_refill_arbiter: RTL and testbench
=======================================

# cache_refill_arbiter

Shares the single main-memory word port between instruction-cache and data-cache line refills, including dirty-victim writeback for the data cache. It sequences each miss as a burst of single-word memory transactions. It returns fill words to the owning cache and drives the ICacheMiss/DCacheMiss stall inputs of the pipeline hazard unit. It sits between the two L1 caches and the memory interface, beside the hazard unit.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width; word stride is DATA_W/8 bytes
- LINE_WORDS, 4, words per line; power of two, 2..16; IDX_W = log2(LINE_WORDS)

- clk  in  1  clock; everything registers on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- IMissReq  in  1  I-cache miss request; held until IFillDone
- IMissAddr  in  ADDR_W  I line base address (low bits zero); stable while IMissReq
- IFillValid  out  1  I fill word valid (one-cycle strobe per word)
- IFillIdx  out  IDX_W  word index of the I fill word
- IFillData  out  DATA_W  I fill word
- IFillDone  out  1  one-cycle pulse: I line complete
- DMissReq  in  1  D-cache miss request; held until DFillDone
- DMissAddr  in  ADDR_W  D refill line base address
- DDirty  in  1  victim line dirty; sampled at grant
- DVictimAddr  in  ADDR_W  victim line base address
- DVictimIdx  out  IDX_W  victim word index being written back
- DVictimData  in  DATA_W  victim word at DVictimIdx, same-cycle combinational read
- DFillValid, DFillIdx, DFillData, DFillDone  out  1/IDX_W/DATA_W/1  D-side counterparts of the I fill outputs
- MemReq  out  1  memory word request
- MemWe  out  1  1 = write, 0 = read
- MemAddr  out  ADDR_W  word byte address
- MemWData  out  DATA_W  write data
- MemRData  in  DATA_W  read data, valid when MemAck
- MemAck  in  1  current word transaction complete
- ICacheMiss  out  1  stall request to the hazard unit, I side
- DCacheMiss  out  1  stall request to the hazard unit, D side
- Busy  out  1  state != IDLE

## Operation
- States are IDLE, D_WB, D_FILL, I_FILL and DONE. There is a registered owner bit (I/D) and a beat counter cnt of IDX_W bits.
- IDLE:
  - If DMissReq: the owner becomes D and cnt resets to 0. The next state is D_WB if DDirty, otherwise D_FILL.
  - Else if IMissReq: the owner becomes I, cnt resets to 0 and the next state is I_FILL.
  - D has fixed priority over I. A granted burst is never preempted.
- D_WB:
  - Outputs: MemReq=1, MemWe=1, MemAddr = DVictimAddr + cnt*(DATA_W/8), MemWData = DVictimData, DVictimIdx = cnt.
  - On MemAck, cnt increments. On MemAck with cnt == LINE_WORDS-1, cnt wraps to 0 and the state moves to D_FILL.
- D_FILL / I_FILL:
  - Outputs: MemReq=1, MemWe=0, MemAddr = line base + cnt*(DATA_W/8).
  - On MemAck, the owner's FillValid=1, FillIdx=cnt and FillData=MemRData, all combinational in the ack cycle, and cnt increments.
  - The last beat moves the state to DONE.
- DONE:
  - The owner's FillDone=1 for exactly one cycle, then the state moves to IDLE.
  - The requester drops its MissReq at the clock edge that ends the Done cycle, so IDLE never regrants a stale request.
- Stall outputs:
  - ICacheMiss = IMissReq & ~IFillDone.
  - DCacheMiss = DMissReq & ~DFillDone.
  - Both are combinational, so the stall releases in the Done cycle.
- Address arithmetic is modulo 2^ADDR_W; line bases are aligned, so there is no line crossing.
- All fill, victim-index and memory outputs are 0 whenever they are not active per the rules above.

## Timing
- Reset (async assert, sync release): state=IDLE, owner=I, cnt=0. Every output is 0: MemReq, MemWe, MemAddr, MemWData, all Fill*, DVictimIdx, ICacheMiss, DCacheMiss, Busy.
- Reset mid-burst abandons the transaction immediately. MemReq drops asynchronously. No Done is issued.
- MemReq rises the cycle after a request is seen in IDLE. MemReq, MemAddr, MemWe and MemWData are held stable until MemAck.
- After an ack, MemReq stays high and the address advances at that edge. With zero-wait memory (MemAck in the same cycle as MemReq), the burst issues one word per cycle.
- Clean D or I miss with zero-wait memory: request at cycle 0, beats at cycles 1..LINE_WORDS, Done at LINE_WORDS+1, IDLE at LINE_WORDS+2.
- Dirty D miss: the LINE_WORDS write beats come first, then the read beats. Done is at cycle 2*LINE_WORDS+1.
- Simultaneous IMissReq and DMissReq: D is served fully, I is granted in the IDLE cycle after D's Done, and ICacheMiss stays high throughout.
- MemAck while MemReq=0 is ignored.

## Test plan
- Clean I miss, IMissAddr=0x1000, zero-wait memory returning addr^0xFFFF: MemAddr 0x1000,0x1004,0x1008,0x100C; IFillIdx 0..3 with the matching data; IFillDone at cycle 5; ICacheMiss low in cycle 5.
- Dirty D miss, victim 0x2000, refill 0x3000: 4 writes to 0x2000..0x200C carrying DVictimData for DVictimIdx 0..3, then 4 reads from 0x3000..0x300C; DFillDone at cycle 9.
- IMissReq and DMissReq asserted in the same cycle: D burst first; I burst starts in the cycle after DFillDone; no interleaved MemAddr.
- Memory with 3 wait states per word: address and control held for 4 cycles per beat; clean-line DFillDone at cycle 17.
- rst_n pulsed low during beat 2 of an I fill: all outputs 0 during reset; no IFillDone; after release with IMissReq still high, the burst restarts at cnt=0 with address 0x1000.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
// Shares one main-memory word port between I-cache and D-cache line refills.
// A D miss with a dirty victim writes the victim line back before the refill.
// D has fixed priority over I, and a granted burst always runs to completion.
// Fill strobes are combinational in the MemAck cycle.
// Done is a one-cycle pulse, and the stall outputs release in that same cycle.

module cache_refill_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              IMissReq,
    input  logic [ADDR_W-1:0] IMissAddr,
    output logic              IFillValid,
    output logic [IDX_W-1:0]  IFillIdx,
    output logic [DATA_W-1:0] IFillData,
    output logic              IFillDone,
    // D-cache side
    input  logic              DMissReq,
    input  logic [ADDR_W-1:0] DMissAddr,
    input  logic              DDirty,
    input  logic [ADDR_W-1:0] DVictimAddr,
    output logic [IDX_W-1:0]  DVictimIdx,
    input  logic [DATA_W-1:0] DVictimData,
    output logic              DFillValid,
    output logic [IDX_W-1:0]  DFillIdx,
    output logic [DATA_W-1:0] DFillData,
    output logic              DFillDone,
    // memory word port
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    // hazard unit
    output logic              ICacheMiss,
    output logic              DCacheMiss,
    output logic              Busy
);

    localparam int unsigned STRIDE = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_WB,
        S_D_FILL,
        S_I_FILL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner_d;     // 1 = D owns the port, 0 = I
    logic              w_owner_d_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_offset;
    logic              w_last;

    assign w_offset = ADDR_W'(r_cnt) * ADDR_W'(STRIDE);
    assign w_last   = (r_cnt == IDX_W'(LINE_WORDS - 1));

    // State, owner and beat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner_d <= w_owner_d_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state logic plus memory, fill and victim-index outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_d_nxt = r_owner_d;
        w_cnt_nxt     = r_cnt;
        MemReq        = 1'b0;
        MemWe         = 1'b0;
        MemAddr       = '0;
        MemWData      = '0;
        DVictimIdx    = '0;
        IFillValid    = 1'b0;
        IFillIdx      = '0;
        IFillData     = '0;
        IFillDone     = 1'b0;
        DFillValid    = 1'b0;
        DFillIdx      = '0;
        DFillData     = '0;
        DFillDone     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (DMissReq) begin
                    w_owner_d_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = DDirty ? S_D_WB : S_D_FILL;
                end else if (IMissReq) begin
                    w_owner_d_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_I_FILL;
                end
            end
            S_D_WB: begin
                MemReq     = 1'b1;
                MemWe      = 1'b1;
                MemAddr    = DVictimAddr + w_offset;
                MemWData   = DVictimData;
                DVictimIdx = r_cnt;
                if (MemAck) begin
                    // The counter wraps to 0 on the last write beat, ready for the refill.
                    w_cnt_nxt = r_cnt + IDX_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_D_FILL;
                    end
                end
            end
            S_D_FILL: begin
                MemReq  = 1'b1;
                MemAddr = DMissAddr + w_offset;
                if (MemAck) begin
                    DFillValid = 1'b1;
                    DFillIdx   = r_cnt;
                    DFillData  = MemRData;
                    w_cnt_nxt  = r_cnt + IDX_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_I_FILL: begin
                MemReq  = 1'b1;
                MemAddr = IMissAddr + w_offset;
                if (MemAck) begin
                    IFillValid = 1'b1;
                    IFillIdx   = r_cnt;
                    IFillData  = MemRData;
                    w_cnt_nxt  = r_cnt + IDX_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (r_owner_d) begin
                    DFillDone = 1'b1;
                end else begin
                    IFillDone = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall requests to the hazard unit; forced low while reset is asserted
    always_comb begin
        ICacheMiss = rst_n & IMissReq & ~IFillDone;
        DCacheMiss = rst_n & DMissReq & ~DFillDone;
        Busy       = (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Testbench for cache_refill_arbiter.
// A transaction-level reference model queues the expected memory beats for each grant.
// Every cycle, the DUT outputs are compared against that model.
// Directed scenarios also pin the model with hand-computed literal values.

module tb_cache_refill_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          IMissReq, DMissReq, DDirty, MemAck;
    logic [AW-1:0] IMissAddr, DMissAddr, DVictimAddr;
    logic          IFillValid, IFillDone, DFillValid, DFillDone;
    logic [IW-1:0] IFillIdx, DFillIdx, DVictimIdx;
    logic [DW-1:0] IFillData, DFillData, DVictimData, MemWData, MemRData;
    logic          MemReq, MemWe, ICacheMiss, DCacheMiss, Busy;
    logic [AW-1:0] MemAddr;

    logic [DW-1:0] vmem [LW];
    logic [DW-1:0] salt;

    always #5 clk = ~clk;

    // Victim line storage (combinational read) and a memory whose data is address-derived
    assign DVictimData = vmem[DVictimIdx];
    assign MemRData    = MemAddr ^ salt;

    cache_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IMissReq(IMissReq), .IMissAddr(IMissAddr), .IFillValid(IFillValid),
        .IFillIdx(IFillIdx), .IFillData(IFillData), .IFillDone(IFillDone),
        .DMissReq(DMissReq), .DMissAddr(DMissAddr), .DDirty(DDirty),
        .DVictimAddr(DVictimAddr), .DVictimIdx(DVictimIdx), .DVictimData(DVictimData),
        .DFillValid(DFillValid), .DFillIdx(DFillIdx), .DFillData(DFillData),
        .DFillDone(DFillDone), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss), .Busy(Busy)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: the pending beats of the granted burst plus a done flag
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        int unsigned   idx;
        logic          own_d;
    } beat_t;

    beat_t q[$];
    bit    m_done;
    bit    m_done_d;

    // Stimulus control
    int    ack_mode;   // 0 zero-wait, 1 three wait states, 2 random
    int    wcnt;
    bit    rnd_req;
    bit    prev_idone, prev_ddone;
    int    cyc = 0;
    int    t0  = 0;

    // Per-cycle capture, relative to t0, for the literal checks
    logic [31:0] log_addr  [64];
    logic        log_req   [64];
    logic        log_we    [64];
    logic [31:0] log_wdata [64];
    logic [31:0] log_vidx  [64];
    logic        log_ifv   [64];
    logic [31:0] log_ifidx [64];
    logic [31:0] log_ifdat [64];
    logic        log_idone [64];
    logic        log_dfv   [64];
    logic        log_ddone [64];
    logic        log_icm   [64];
    logic        log_busy  [64];

    task automatic grant_d();
        for (int k = 0; k < LW; k++)
            if (DDirty) q.push_back('{1'b1, DVictimAddr + AW'(k * (DW / 8)), k, 1'b1});
        for (int k = 0; k < LW; k++)
            q.push_back('{1'b0, DMissAddr + AW'(k * (DW / 8)), k, 1'b1});
    endtask

    task automatic grant_i();
        for (int k = 0; k < LW; k++)
            q.push_back('{1'b0, IMissAddr + AW'(k * (DW / 8)), k, 1'b0});
    endtask

    task automatic model_update();
        beat_t h;
        if (!rst_n) begin
            q.delete();
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (q.size() > 0) begin
            if (MemAck) begin
                h = q.pop_front();
                if (q.size() == 0) begin
                    m_done   = 1;
                    m_done_d = h.own_d;
                end
            end
        end else if (DMissReq) begin
            grant_d();
        end else if (IMissReq) begin
            grant_i();
        end
    endtask

    task automatic drive();
        if (prev_idone) IMissReq = 1'b0;
        if (prev_ddone) DMissReq = 1'b0;
        if (rnd_req) begin
            if (!IMissReq && !prev_idone && $urandom_range(3) == 0) begin
                IMissReq  = 1'b1;
                IMissAddr = $urandom & ~32'hF;
            end
            if (!DMissReq && !prev_ddone && $urandom_range(3) == 0) begin
                DMissReq    = 1'b1;
                DMissAddr   = $urandom & ~32'hF;
                DVictimAddr = $urandom & ~32'hF;
                DDirty      = 1'($urandom_range(1));
                for (int k = 0; k < LW; k++) vmem[k] = $urandom;
            end
        end
        case (ack_mode)
            0: MemAck = 1'b1;
            1: begin
                if (MemReq) begin
                    MemAck = (wcnt == 3);
                    wcnt   = MemAck ? 0 : wcnt + 1;
                end else begin
                    MemAck = 1'b0;
                    wcnt   = 0;
                end
            end
            default: MemAck = ($urandom_range(2) == 0);
        endcase
    endtask

    task automatic check_cycle();
        logic          e_req, e_we, e_ifv, e_idone, e_dfv, e_ddone, e_icm, e_dcm, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_ifdat, e_dfdat;
        logic [31:0]   e_vidx, e_ifidx, e_dfidx;
        int            rel;
        beat_t         h;
        e_req = 0; e_we = 0; e_ifv = 0; e_idone = 0; e_dfv = 0; e_ddone = 0; e_busy = 0;
        e_addr = '0; e_wdata = '0; e_ifdat = '0; e_dfdat = '0;
        e_vidx = 0; e_ifidx = 0; e_dfidx = 0;
        if (rst_n && q.size() > 0) begin
            h      = q[0];
            e_req  = 1; e_we = h.we; e_addr = h.addr; e_busy = 1;
            if (h.we) begin
                e_wdata = vmem[h.idx];
                e_vidx  = h.idx;
            end else if (MemAck) begin
                if (h.own_d) begin
                    e_dfv = 1; e_dfidx = h.idx; e_dfdat = h.addr ^ salt;
                end else begin
                    e_ifv = 1; e_ifidx = h.idx; e_ifdat = h.addr ^ salt;
                end
            end
        end
        if (rst_n && m_done) begin
            e_busy = 1;
            if (m_done_d) e_ddone = 1; else e_idone = 1;
        end
        e_icm = rst_n & IMissReq & ~e_idone;
        e_dcm = rst_n & DMissReq & ~e_ddone;

        chk("MemReq", MemReq, e_req);
        chk("MemWe", MemWe, e_we);
        chk("MemAddr", MemAddr, e_addr);
        chk("MemWData", MemWData, e_wdata);
        chk("DVictimIdx", DVictimIdx, e_vidx);
        chk("IFillValid", IFillValid, e_ifv);
        chk("IFillIdx", IFillIdx, e_ifidx);
        chk("IFillData", IFillData, e_ifdat);
        chk("IFillDone", IFillDone, e_idone);
        chk("DFillValid", DFillValid, e_dfv);
        chk("DFillIdx", DFillIdx, e_dfidx);
        chk("DFillData", DFillData, e_dfdat);
        chk("DFillDone", DFillDone, e_ddone);
        chk("ICacheMiss", ICacheMiss, e_icm);
        chk("DCacheMiss", DCacheMiss, e_dcm);
        chk("Busy", Busy, e_busy);

        prev_idone = e_idone;
        prev_ddone = e_ddone;

        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            log_addr[rel]  = MemAddr;   log_req[rel]   = MemReq;
            log_we[rel]    = MemWe;     log_wdata[rel] = MemWData;
            log_vidx[rel]  = 32'(DVictimIdx);
            log_ifv[rel]   = IFillValid; log_ifidx[rel] = 32'(IFillIdx);
            log_ifdat[rel] = IFillData; log_idone[rel] = IFillDone;
            log_dfv[rel]   = DFillValid; log_ddone[rel] = DFillDone;
            log_icm[rel]   = ICacheMiss; log_busy[rel] = Busy;
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, advance model at the next edge
    task automatic cycle();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        IMissReq = 0; DMissReq = 0; DDirty = 0; MemAck = 0;
        IMissAddr = '0; DMissAddr = '0; DVictimAddr = '0;
        salt = 32'h0000_FFFF;
        for (int k = 0; k < LW; k++) vmem[k] = 32'hA5A5_0000 + 32'(k);
        ack_mode = 0; wcnt = 0; rnd_req = 0;
        prev_idone = 0; prev_ddone = 0; m_done = 0; m_done_d = 0;
        @(posedge clk);
        #1;

        // Reset state, with IMissReq already asserted to show that the stall is masked
        IMissReq = 1'b1; IMissAddr = 32'h1000;
        t0 = cyc;
        run(2);
        chk("rst_busy", log_busy[0], 1'b0);
        chk("rst_memreq", log_req[0], 1'b0);
        chk("rst_icm", log_icm[1], 1'b0);
        IMissReq = 1'b0;
        rst_n = 1'b1;
        run(2);

        // Clean I miss at 0x1000, zero-wait memory
        IMissReq = 1'b1; IMissAddr = 32'h1000;
        t0 = cyc;
        run(8);
        chk("i_req_c0", log_req[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("i_addr", log_addr[k+1], 32'h1000 + 32'(4 * k));
            chk("i_fidx", log_ifidx[k+1], 32'(k));
            chk("i_fv", log_ifv[k+1], 1'b1);
        end
        chk("i_fdat1", log_ifdat[1], 32'h0000_EFFF);
        chk("i_fdat4", log_ifdat[4], 32'h0000_EFF3);
        chk("i_done4", log_idone[4], 1'b0);
        chk("i_done5", log_idone[5], 1'b1);
        chk("i_icm4", log_icm[4], 1'b1);
        chk("i_icm5", log_icm[5], 1'b0);
        chk("i_busy6", log_busy[6], 1'b0);

        // Dirty D miss: victim 0x2000, refill 0x3000
        for (int k = 0; k < LW; k++) vmem[k] = 32'hD00D_0000 + 32'(k * 17);
        DMissReq = 1'b1; DDirty = 1'b1; DVictimAddr = 32'h2000; DMissAddr = 32'h3000;
        t0 = cyc;
        run(12);
        for (int k = 0; k < 4; k++) begin
            chk("wb_addr", log_addr[k+1], 32'h2000 + 32'(4 * k));
            chk("wb_we", log_we[k+1], 1'b1);
            chk("wb_vidx", log_vidx[k+1], 32'(k));
            chk("wb_wdata", log_wdata[k+1], 32'hD00D_0000 + 32'(k * 17));
            chk("df_addr", log_addr[k+5], 32'h3000 + 32'(4 * k));
            chk("df_we", log_we[k+5], 1'b0);
        end
        chk("d_done8", log_ddone[8], 1'b0);
        chk("d_done9", log_ddone[9], 1'b1);
        DDirty = 1'b0;

        // Simultaneous I and D requests: D served first, I follows without interleaving
        IMissReq = 1'b1; IMissAddr = 32'h1000;
        DMissReq = 1'b1; DMissAddr = 32'h4000;
        t0 = cyc;
        run(14);
        chk("sim_d_addr4", log_addr[4], 32'h400C);
        chk("sim_d_done5", log_ddone[5], 1'b1);
        chk("sim_req6", log_req[6], 1'b0);
        chk("sim_i_addr7", log_addr[7], 32'h1000);
        chk("sim_i_addr10", log_addr[10], 32'h100C);
        chk("sim_icm6", log_icm[6], 1'b1);
        chk("sim_icm10", log_icm[10], 1'b1);
        chk("sim_i_done11", log_idone[11], 1'b1);
        chk("sim_icm11", log_icm[11], 1'b0);

        // Three wait states per word, clean D line at 0x5000
        ack_mode = 1; wcnt = 0;
        DMissReq = 1'b1; DMissAddr = 32'h5000;
        t0 = cyc;
        run(20);
        chk("ws_addr1", log_addr[1], 32'h5000);
        chk("ws_addr4", log_addr[4], 32'h5000);
        chk("ws_addr5", log_addr[5], 32'h5004);
        chk("ws_fv3", log_dfv[3], 1'b0);
        chk("ws_fv4", log_dfv[4], 1'b1);
        chk("ws_done16", log_ddone[16], 1'b0);
        chk("ws_done17", log_ddone[17], 1'b1);
        ack_mode = 0;

        // Reset pulse during beat 2 of an I fill; the burst restarts from word 0
        IMissReq = 1'b1; IMissAddr = 32'h1000;
        t0 = cyc;
        run(3);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(8);
        chk("rp_beat1", log_ifidx[2], 32'd1);
        chk("rp_req3", log_req[3], 1'b0);
        chk("rp_icm3", log_icm[3], 1'b0);
        chk("rp_busy3", log_busy[3], 1'b0);
        chk("rp_done4", log_idone[4], 1'b0);
        chk("rp_addr5", log_addr[5], 32'h1000);
        chk("rp_idx5", log_ifidx[5], 32'd0);
        chk("rp_done9", log_idone[9], 1'b1);

        // Randomized traffic: random acks (including acks while idle), then zero-wait
        salt = $urandom;
        rnd_req = 1; ack_mode = 2;
        run(3000);
        salt = $urandom;
        ack_mode = 0;
        run(1500);

        // Drain outstanding requests, with a bounded wait
        rnd_req = 0; ack_mode = 2;
        begin
            int n;
            n = 0;
            while ((IMissReq || DMissReq || Busy) && n < 400) begin
                cycle();
                n++;
            end
            chk("drain_timeout", 32'(n < 400), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
